jtag_tap_ctrl: RTL and testbench

//  IEEE 1149.1-style TAP controller and instruction decoder for the s9234 boundary-scan wrapper.

---
 rtl/jtag_tap_ctrl_pkg.sv | 42 ++++
 rtl/jtag_tap_ctrl_if.sv | 28 ++
 rtl/jtag_tap_ctrl_ir.sv | 62 ++++++
 rtl/jtag_tap_ctrl.sv | 108 ++++++++++
 tb/tb_jtag_tap_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared types, opcodes and the 1149.1 TMS transition graph for the s9234 TAP controller.
package jtag_tap_ctrl_pkg;

    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPaDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPaIr, StEx2Ir, StUpdIr
    } tap_state_t;

    localparam int unsigned IR_W_DEF     = 4;
    localparam int unsigned OP_EXTEST    = 0;
    localparam int unsigned OP_SAMPLE    = 1;
    localparam int unsigned OP_INTEST_IS = 2;
    localparam int unsigned OP_IDCODE    = 3;

    // Low bits of the IR capture value; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            StTlr:   n = tms ? StTlr   : StRti;
            StRti:   n = tms ? StSelDr : StRti;
            StSelDr: n = tms ? StSelIr : StCapDr;
            StCapDr: n = tms ? StEx1Dr : StShDr;
            StShDr:  n = tms ? StEx1Dr : StShDr;
            StEx1Dr: n = tms ? StUpdDr : StPaDr;
            StPaDr:  n = tms ? StEx2Dr : StPaDr;
            StEx2Dr: n = tms ? StUpdDr : StShDr;
            StUpdDr: n = tms ? StSelDr : StRti;
            StSelIr: n = tms ? StTlr   : StCapIr;
            StCapIr: n = tms ? StEx1Ir : StShIr;
            StShIr:  n = tms ? StEx1Ir : StShIr;
            StEx1Ir: n = tms ? StUpdIr : StPaIr;
            StPaIr:  n = tms ? StEx2Ir : StPaIr;
            StEx2Ir: n = tms ? StUpdIr : StShIr;
            StUpdIr: n = tms ? StSelDr : StRti;
            default: n = StTlr;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Serial test-port and chain-control signals between the TAP controller and its environment.
interface jtag_tap_ctrl_if #(
    parameter int unsigned IR_W = jtag_tap_ctrl_pkg::IR_W_DEF
);
    logic            TMS;
    logic            TDI;
    logic            TDO_BSR;
    logic            TDO_ISR;
    logic            clockdr;
    logic            updatedr;
    logic            shiftdr;
    logic            clockdr_is;
    logic            updatedr_is;
    logic            shiftdr_is;
    logic            TDO;
    logic            TDO_EN;
    logic [IR_W-1:0] ir_q;

    modport master (
        output TMS, TDI, TDO_BSR, TDO_ISR,
        input  clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is, TDO, TDO_EN, ir_q
    );

    modport slave (
        input  TMS, TDI, TDO_BSR, TDO_ISR,
        output clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is, TDO, TDO_EN, ir_q
    );
endinterface

// File: rtl/jtag_tap_ctrl_ir.sv
// Instruction shift/update registers and chain-select decode.
// JTAG_IDCODE_EN makes IDCODE the reset instruction and enables its decode.
module jtag_tap_ctrl_ir
    import jtag_tap_ctrl_pkg::*;
#(
    parameter int unsigned IR_W = IR_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  tap_state_t      i_state_q,
    input  tap_state_t      i_state_d,
    input  logic            i_tdi,
    output logic            o_ir_lsb,
    output logic [IR_W-1:0] o_ir_q,
    output logic            o_sel_bsr,
    output logic            o_sel_isr,
    output logic            o_sel_byp,
    output logic            o_sel_id
);
    localparam logic [IR_W-1:0] IrCapture = IR_W'(IR_CAPTURE_LSBS);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IrReset = IR_W'(OP_IDCODE);
`else
    localparam logic [IR_W-1:0] IrReset = '1;
`endif

    logic [IR_W-1:0] r_ir_sr;
    logic [IR_W-1:0] r_ir_q;

    // Shift acts on the state being left; the update register follows next-state decode.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ir_sr <= IrCapture;
            r_ir_q  <= IrReset;
        end else begin
            if (i_state_q == StCapIr) begin
                r_ir_sr <= IrCapture;
            end else if (i_state_q == StShIr) begin
                r_ir_sr <= {i_tdi, r_ir_sr[IR_W-1:1]};
            end
            if (i_state_d == StTlr) begin
                r_ir_q <= IrReset;
            end else if (i_state_d == StUpdIr) begin
                r_ir_q <= r_ir_sr;
            end
        end
    end

    always_comb begin
        o_sel_bsr = (r_ir_q == IR_W'(OP_EXTEST)) || (r_ir_q == IR_W'(OP_SAMPLE));
        o_sel_isr = (r_ir_q == IR_W'(OP_INTEST_IS));
`ifdef JTAG_IDCODE_EN
        o_sel_id  = (r_ir_q == IR_W'(OP_IDCODE));
`else
        o_sel_id  = 1'b0;
`endif
        o_sel_byp = !(o_sel_bsr || o_sel_isr || o_sel_id);
    end

    assign o_ir_lsb = r_ir_sr[0];
    assign o_ir_q   = r_ir_q;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller driving the s9234 BSR/ISR chains; TDO mux and bypass/ID registers.
// JTAG_IDCODE_EN adds the 32-bit ID register and the IDCODE instruction.
module jtag_tap_ctrl
    import jtag_tap_ctrl_pkg::*;
#(
    parameter int unsigned IR_W = IR_W_DEF
`ifdef JTAG_IDCODE_EN
  , parameter logic [31:0] IDCODE_VAL = 32'h0923_4001
`endif
) (
    input logic              CK,
    input logic              RST,
    jtag_tap_ctrl_if.slave   bus
);
    tap_state_t r_state;
    tap_state_t w_state_d;
    logic       w_ir_lsb;
    logic       w_sel_bsr, w_sel_isr, w_sel_byp, w_sel_id;
    logic       w_dr_act, w_dr_bit, w_tdo_d;
    logic       r_byp, r_tdo, r_tdo_en;
    logic       r_clockdr, r_shiftdr, r_updatedr;
    logic       r_clockdr_is, r_shiftdr_is, r_updatedr_is;
`ifdef JTAG_IDCODE_EN
    logic [31:0] r_id_sr;
`endif

    jtag_tap_ctrl_ir #(.IR_W(IR_W)) u_ir (
        .i_clk     (CK),
        .i_rst     (RST),
        .i_state_q (r_state),
        .i_state_d (w_state_d),
        .i_tdi     (bus.TDI),
        .o_ir_lsb  (w_ir_lsb),
        .o_ir_q    (bus.ir_q),
        .o_sel_bsr (w_sel_bsr),
        .o_sel_isr (w_sel_isr),
        .o_sel_byp (w_sel_byp),
        .o_sel_id  (w_sel_id)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) r_state <= StTlr;
        else     r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = tap_next(r_state, bus.TMS);
        w_dr_act  = (w_state_d == StCapDr) || (w_state_d == StShDr);
        w_dr_bit  = 1'b0;
        unique case (1'b1)
            w_sel_bsr: w_dr_bit = bus.TDO_BSR;
            w_sel_isr: w_dr_bit = bus.TDO_ISR;
            w_sel_byp: w_dr_bit = r_byp;
`ifdef JTAG_IDCODE_EN
            w_sel_id:  w_dr_bit = r_id_sr[0];
`else
            w_sel_id:  w_dr_bit = 1'b0;
`endif
        endcase
        w_tdo_d = 1'b0;
        if (r_state == StShIr)      w_tdo_d = w_ir_lsb;
        else if (r_state == StShDr) w_tdo_d = w_dr_bit;
    end

    // Strobes come from next-state decode so they coincide with the state they name.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_clockdr     <= 1'b0;
            r_shiftdr     <= 1'b0;
            r_updatedr    <= 1'b0;
            r_clockdr_is  <= 1'b0;
            r_shiftdr_is  <= 1'b0;
            r_updatedr_is <= 1'b0;
            r_tdo         <= 1'b0;
            r_tdo_en      <= 1'b0;
            r_byp         <= 1'b0;
        end else begin
            r_clockdr     <= w_dr_act && w_sel_bsr;
            r_shiftdr     <= (w_state_d == StShDr) && w_sel_bsr;
            r_updatedr    <= (w_state_d == StUpdDr) && w_sel_bsr;
            r_clockdr_is  <= w_dr_act && w_sel_isr;
            r_shiftdr_is  <= (w_state_d == StShDr) && w_sel_isr;
            r_updatedr_is <= (w_state_d == StUpdDr) && w_sel_isr;
            r_tdo         <= w_tdo_d;
            r_tdo_en      <= (r_state == StShIr) || (r_state == StShDr);
            if (r_state == StCapDr)      r_byp <= 1'b0;
            else if (r_state == StShDr)  r_byp <= bus.TDI;
            else if (w_state_d == StTlr) r_byp <= 1'b0;
        end
    end

`ifdef JTAG_IDCODE_EN
    always_ff @(posedge CK or posedge RST) begin
        if (RST)                                r_id_sr <= IDCODE_VAL;
        else if (r_state == StCapDr && w_sel_id) r_id_sr <= IDCODE_VAL;
        else if (r_state == StShDr && w_sel_id)  r_id_sr <= {bus.TDI, r_id_sr[31:1]};
    end
`endif

    assign bus.clockdr     = r_clockdr;
    assign bus.shiftdr     = r_shiftdr;
    assign bus.updatedr    = r_updatedr;
    assign bus.clockdr_is  = r_clockdr_is;
    assign bus.shiftdr_is  = r_shiftdr_is;
    assign bus.updatedr_is = r_updatedr_is;
    assign bus.TDO         = r_tdo;
    assign bus.TDO_EN      = r_tdo_en;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scans plus a random TMS walk against a queue model.
module tb_jtag_tap_ctrl;
    localparam int IRW = 4;
    localparam logic [31:0] ID_VAL = 32'h0923_4001;
`ifdef JTAG_IDCODE_EN
    localparam int RESET_OP = 3;
`else
    localparam int RESET_OP = 15;
`endif
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    int next0[16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI,
                      CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
    int next1[16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR,
                      TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};

    logic CK = 1'b0;
    logic RST = 1'b1;
    jtag_tap_ctrl_if #(.IR_W(IRW)) bus ();
    jtag_tap_ctrl #(.IR_W(IRW)) dut (.CK(CK), .RST(RST), .bus(bus));

    always #5 CK = ~CK;

    int n_checks = 0;
    int n_errors = 0;
    int ms, mir;
    bit exp_tdo, exp_en;
    bit irq[$];
    bit dq[$];
    int cnt_cd, cnt_sd, cnt_ud, cnt_cdi, cnt_sdi, cnt_udi;
    logic [63:0] tdo_obs;
    logic [IRW-1:0] ir_obs;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 = BSR, 1 = ISR, 2 = bypass, 3 = ID
    function automatic int chain_of(input int op);
        if (op == 0 || op == 1) return 0;
        if (op == 2) return 1;
`ifdef JTAG_IDCODE_EN
        if (op == 3) return 3;
`endif
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = TLR;
        mir = RESET_OP;
        exp_tdo = 1'b0;
        exp_en = 1'b0;
        irq.delete();
        dq.delete();
    endtask

    task automatic model_step(input bit tms, input bit tdi, input bit bsr, input bit isr);
        int ch, ns;
        ch = chain_of(mir);
        exp_tdo = 1'b0;
        exp_en = 1'b0;
        if (ms == SHIR) begin
            exp_en = 1'b1;
            exp_tdo = irq.pop_front();
            irq.push_back(tdi);
        end else if (ms == SHDR) begin
            exp_en = 1'b1;
            if (ch == 0) exp_tdo = bsr;
            else if (ch == 1) exp_tdo = isr;
            else begin
                exp_tdo = dq.pop_front();
                dq.push_back(tdi);
            end
        end else if (ms == CIR) begin
            irq.delete();
            for (int i = 0; i < IRW; i++) irq.push_back(i == 0);
        end else if (ms == CDR) begin
            dq.delete();
            if (ch == 3) for (int i = 0; i < 32; i++) dq.push_back(ID_VAL[i]);
            else dq.push_back(1'b0);
        end
        ns = tms ? next1[ms] : next0[ms];
        if (ns == UIR) begin
            mir = 0;
            foreach (irq[i]) if (irq[i]) mir |= (1 << i);
        end
        if (ns == TLR) mir = RESET_OP;
        ms = ns;
    endtask

    task automatic check_all(input string tag);
        int ch;
        bit cs, sh, up;
        logic [5:0] obs, exp;
        ch = chain_of(mir);
        cs = (ms == CDR) || (ms == SHDR);
        sh = (ms == SHDR);
        up = (ms == UDR);
        exp = {cs && ch == 0, sh && ch == 0, up && ch == 0, cs && ch == 1, sh && ch == 1, up && ch == 1};
        obs = {bus.clockdr, bus.shiftdr, bus.updatedr, bus.clockdr_is, bus.shiftdr_is, bus.updatedr_is};
        check($sformatf("%s strobes", tag), 32'(obs), 32'(exp));
        check($sformatf("%s TDO", tag), 32'(bus.TDO), 32'(exp_tdo));
        check($sformatf("%s TDO_EN", tag), 32'(bus.TDO_EN), 32'(exp_en));
        check($sformatf("%s ir_q", tag), 32'(bus.ir_q), 32'(mir));
    endtask

    task automatic tick(input bit tms, input bit tdi, input string tag);
        bit b, s;
        @(negedge CK);
        b = rb();
        s = rb();
        bus.TMS = tms;
        bus.TDI = tdi;
        bus.TDO_BSR = b;
        bus.TDO_ISR = s;
        @(posedge CK);
        model_step(tms, tdi, b, s);
        #1;
        check_all(tag);
        cnt_cd += int'(bus.clockdr);
        cnt_sd += int'(bus.shiftdr);
        cnt_ud += int'(bus.updatedr);
        cnt_cdi += int'(bus.clockdr_is);
        cnt_sdi += int'(bus.shiftdr_is);
        cnt_udi += int'(bus.updatedr_is);
    endtask

    task automatic clear_counts();
        cnt_cd = 0; cnt_sd = 0; cnt_ud = 0; cnt_cdi = 0; cnt_sdi = 0; cnt_udi = 0;
    endtask

    // From RTI: full IR scan of op, back to RTI.
    task automatic load_ir(input logic [IRW-1:0] op, input string tag);
        tick(1, rb(), tag); tick(1, rb(), tag); tick(0, rb(), tag); tick(0, rb(), tag);
        for (int i = 0; i < IRW; i++) begin
            tick(i == IRW - 1, op[i], tag);
            ir_obs[i] = bus.TDO;
        end
        tick(1, rb(), tag); tick(0, rb(), tag);
        check($sformatf("%s loaded", tag), 32'(bus.ir_q), 32'(op));
    endtask

    // From RTI: DR scan of n bits (optionally pausing and shifting one more), back to RTI.
    task automatic dr_scan(input int n, input logic [63:0] data, input bit pause, input string tag);
        tick(1, rb(), tag); tick(0, rb(), tag); tick(0, rb(), tag);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, data[i], tag);
            tdo_obs[i] = bus.TDO;
        end
        if (pause) begin
            tick(0, rb(), tag); tick(0, rb(), tag); tick(0, rb(), tag);
            tick(1, rb(), tag); tick(0, rb(), tag); tick(1, rb(), tag);
        end
        tick(1, rb(), tag); tick(0, rb(), tag);
    endtask

    initial begin
        bus.TMS = 1'b1; bus.TDI = 1'b0; bus.TDO_BSR = 1'b0; bus.TDO_ISR = 1'b0;
        clear_counts();
        model_reset();
        repeat (2) @(posedge CK);
        #1;
        check_all("reset");
        @(negedge CK);
        RST = 1'b0;
        tick(0, rb(), "to_rti");

        // IR capture pattern, then SAMPLE with a 10-bit BSR scan
        load_ir(IRW'(1), "ir_sample");
        check("ir_capture_out", 32'(ir_obs), 32'(1));
        clear_counts();
        dr_scan(10, {$urandom(), $urandom()}, 1'b0, "bsr_scan");
        check("bsr_clockdr_cnt", 32'(cnt_cd), 32'd11);
        check("bsr_shiftdr_cnt", 32'(cnt_sd), 32'd10);
        check("bsr_updatedr_cnt", 32'(cnt_ud), 32'd1);
        check("bsr_is_cnt", 32'(cnt_cdi + cnt_sdi + cnt_udi), 32'd0);

        // INTEST_IS: only ISR strobes
        load_ir(IRW'(2), "ir_intest");
        clear_counts();
        dr_scan(7, {$urandom(), $urandom()}, 1'b0, "isr_scan");
        check("isr_clockdr_cnt", 32'(cnt_cdi), 32'd8);
        check("isr_shiftdr_cnt", 32'(cnt_sdi), 32'd7);
        check("isr_updatedr_cnt", 32'(cnt_udi), 32'd1);
        check("isr_bsr_cnt", 32'(cnt_cd + cnt_sd + cnt_ud), 32'd0);

        // BYPASS and an undefined opcode: TDI 1,0,1,1,0 -> TDO 0,1,0,1,1
        load_ir(IRW'(15), "ir_bypass");
        dr_scan(5, 64'b01101, 1'b0, "byp_scan");
        check("byp_tdo_seq", 32'(tdo_obs[4:0]), 32'b11010);
        load_ir(IRW'(7), "ir_op7");
        dr_scan(5, 64'b01101, 1'b0, "op7_scan");
        check("op7_tdo_seq", 32'(tdo_obs[4:0]), 32'b11010);
        dr_scan(6, {$urandom(), $urandom()}, 1'b1, "byp_pause");

        // Five TMS=1 from SH_DR reach TLR and reset ir_q
        load_ir(IRW'(2), "ir_pre_tlr");
        tick(1, rb(), "to_shdr"); tick(0, rb(), "to_shdr"); tick(0, rb(), "to_shdr");
        for (int i = 0; i < 5; i++) tick(1, rb(), "tms5");
        check("tms5_ir_reset", 32'(bus.ir_q), 32'(RESET_OP));

        // Asynchronous reset mid DR-shift
        tick(0, rb(), "to_rti2");
        load_ir(IRW'(0), "ir_extest");
        tick(1, rb(), "to_shdr2"); tick(0, rb(), "to_shdr2"); tick(0, rb(), "to_shdr2");
        tick(0, rb(), "shdr2"); tick(0, rb(), "shdr2");
        @(negedge CK);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge CK);
        RST = 1'b0;

`ifdef JTAG_IDCODE_EN
        tick(0, rb(), "to_rti3");
        dr_scan(32, {$urandom(), $urandom()}, 1'b0, "id_scan");
        check("id_value", tdo_obs[31:0], ID_VAL);
`endif

        // Random TMS walk with random TDI and chain outputs
        for (int i = 0; i < 400; i++) tick(rb(), rb(), "random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
